tachyon_rf_writeback: RTL

TACHYON_RF_WRITEBACK -- requirements
Module: tachyon_rf_writeback

---
 rtl/tachyon_rf_writeback.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tachyon_rf_writeback.sv
// rtl/tachyon_rf_writeback.sv - register file writeback queue merging ALU and LSU results
// Optional feature macro: RF_WB_FWD_EN (adds three read-forwarding ports from the queue)
module tachyon_rf_writeback #(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_WIDTH-1:0]   alu_addr,
  input  logic [REG_WIDTH-1:0]    alu_val,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [REG_WIDTH-1:0]    lsu_val,
  output logic                    wr_enable,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [REG_WIDTH-1:0]    wr_val,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [$clog2(DEPTH):0]  count
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]   fwd_addr [3],
  output logic                    fwd_hit  [3],
  output logic [REG_WIDTH-1:0]    fwd_val  [3]
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [REG_WIDTH-1:0]  mem_val  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  lsu_fire;
  logic                  alu_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [REG_WIDTH-1:0]  push_val;

  // Entry i counted from the head (oldest first) and whether it is occupied
  logic [PTR_W-1:0]      ent_idx   [DEPTH];
  logic                  ent_valid [DEPTH];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign ent_idx[g]   = rd_ptr + PTR_W'(g);
      assign ent_valid[g] = CNT_W'(g) < count;
    end
  endgenerate

  // Readys depend only on occupancy, never on the pop happening this cycle
  assign lsu_ready = rst_n && (count < CNT_W'(DEPTH));
  assign alu_ready = rst_n && (count < CNT_W'(DEPTH)) && !lsu_valid;

  assign lsu_fire  = lsu_valid && lsu_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign push_addr = lsu_fire ? lsu_addr : alu_addr;
  assign push_val  = lsu_fire ? lsu_val  : alu_val;
  // Register 0 is hardwired, so its writes are acknowledged and dropped
  assign push      = (lsu_fire || alu_fire) && (push_addr != '0);
  assign pop       = (count != '0);

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are meaningless unless covered by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_val[wr_ptr]  <= push_val;
    end
  end

  // Registered register-file write port, draining one head entry per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_val    <= '0;
    end else if (pop) begin
      wr_enable <= 1'b1;
      wr_addr   <= mem_addr[rd_ptr];
      wr_val    <= mem_val[rd_ptr];
    end else begin
      wr_enable <= 1'b0;
    end
  end

  // Scoreboard view: every queued destination plus the write on the port now
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy[mem_addr[ent_idx[i]]] = 1'b1;
    end
    if (wr_enable) busy[wr_addr] = 1'b1;
  end

`ifdef RF_WB_FWD_EN
  // Forwarding: scan oldest to newest so the youngest match wins
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      fwd_hit[k] = 1'b0;
      fwd_val[k] = '0;
      if (fwd_addr[k] != '0) begin
        if (wr_enable && (wr_addr == fwd_addr[k])) begin
          fwd_hit[k] = 1'b1;
          fwd_val[k] = wr_val;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i] && (mem_addr[ent_idx[i]] == fwd_addr[k])) begin
            fwd_hit[k] = 1'b1;
            fwd_val[k] = mem_val[ent_idx[i]];
          end
        end
      end
    end
  end
`endif

endmodule
